// File: rtl/pe_array_system_pkg.sv
// Shared encodings for the PE array: streaming op codes, PE FSM states and default widths.
package pe_array_system_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] { OP_COPY = 2'd0, OP_SUM = 2'd1 } op_e;
    typedef enum logic [1:0] { ST_IDLE, ST_READ, ST_DRAIN, ST_DONE } pe_state_e;
endpackage

// File: rtl/pe_lane.sv
// One execution lane: private word memory, DMA read/write address counters, sum accumulator
// and the mux between DMA traffic and direct SIMD load/store access.
module pe_lane
    import pe_array_system_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_en,
    input  logic              rd_last,
    input  logic              op_sum,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_rd,
    input  logic [ADDR_W-1:0] ld_raddr,
    output logic              dma_wr_valid,
    output logic [ADDR_W-1:0] dma_wr_addr,
    output logic [DATA_W-1:0] dma_wr_data,
    output logic              dma_rd_valid,
    output logic [ADDR_W-1:0] dma_rd_addr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] acc_q, acc_d, rdata_q, rdata_d;
    logic              rd_vld_q, rd_vld_d, last_q, last_d;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        // Copy writes every returned word; sum writes once, when the last word returns.
        dma_wr_valid = rd_vld_q & (~op_sum | last_q);
        dma_wr_addr  = dma_wr_valid ? wr_addr_q : '0;
        dma_wr_data  = '0;
        if (dma_wr_valid) dma_wr_data = op_sum ? acc_q + rdata_q : rdata_q;
        dma_rd_valid = rd_en;
        dma_rd_addr  = rd_en ? rd_addr_q : '0;

        rd_vld_d  = rd_en;
        last_d    = rd_en & rd_last;
        rd_addr_d = start ? src_base : (rd_en ? rd_addr_q + ADDR_W'(1) : rd_addr_q);
        wr_addr_d = start ? dst_base : ((dma_wr_valid & ~op_sum) ? wr_addr_q + ADDR_W'(1) : wr_addr_q);
        acc_d     = start ? '0 : (rd_vld_q ? acc_q + rdata_q : acc_q);

        mem_we    = dma_wr_valid | ld_wr;
        mem_waddr = dma_wr_valid ? wr_addr_q : ld_waddr;
        mem_wdata = dma_wr_valid ? dma_wr_data : ld_wdata;
        mem_re    = rd_en | ld_rd;
        mem_raddr = rd_en ? rd_addr_q : ld_raddr;
        rdata_d   = mem_re ? mem[mem_raddr] : rdata_q;
        rdata     = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            acc_q     <= '0;
            rdata_q   <= '0;
            rd_vld_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            acc_q     <= acc_d;
            rdata_q   <= rdata_d;
            rd_vld_q  <= rd_vld_d;
            last_q    <= last_d;
        end
    end
endmodule

// File: rtl/pe_array_system.sv
// Array of processing elements: one streaming-op FSM per PE driving NUM_LANES lockstep lanes,
// plus the per-PE load/store port that reaches lane memories only while the PE is idle.
module pe_array_system
    import pe_array_system_pkg::*;
#(
    parameter int NUM_PE    = 2,
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                clk,
    input  logic                                reset_poweron,
    input  logic [NUM_PE-1:0]                   sys__pe__allSynchronized,
    input  logic [NUM_PE-1:0]                   simd__cntl__valid,
    input  logic [NUM_PE*ADDR_W-1:0]            simd__cntl__rs0,
    input  logic [NUM_PE*2-1:0]                 simd__cntl__rs1,
    input  logic [NUM_PE*NUM_LANES*ADDR_W-1:0]  simd__cntl__lane_r128,
    input  logic [NUM_PE*NUM_LANES*ADDR_W-1:0]  simd__cntl__lane_r129,
    output logic [NUM_PE-1:0]                   pe__sys__ready,
    output logic [NUM_PE-1:0]                   pe__sys__complete,
    output logic [NUM_PE*NUM_LANES-1:0]         dma__memc__write_valid,
    output logic [NUM_PE*NUM_LANES*ADDR_W-1:0]  dma__memc__write_address,
    output logic [NUM_PE*NUM_LANES*DATA_W-1:0]  dma__memc__write_data,
    output logic [NUM_PE*NUM_LANES-1:0]         dma__memc__read_valid,
    output logic [NUM_PE*NUM_LANES*ADDR_W-1:0]  dma__memc__read_address,
    input  logic [NUM_PE-1:0]                   ldst__memc__request,
    output logic [NUM_PE-1:0]                   memc__ldst__granted,
    input  logic [NUM_PE*LANE_W-1:0]            ldst__memc__lane,
    input  logic [NUM_PE-1:0]                   ldst__memc__write_valid,
    input  logic [NUM_PE*ADDR_W-1:0]            ldst__memc__write_address,
    input  logic [NUM_PE*DATA_W-1:0]            ldst__memc__write_data,
    input  logic [NUM_PE-1:0]                   ldst__memc__read_valid,
    input  logic [NUM_PE*ADDR_W-1:0]            ldst__memc__read_address,
    output logic [NUM_PE*DATA_W-1:0]            memc__ldst__read_data,
    output logic [NUM_PE-1:0]                   memc__ldst__read_data_valid
);
    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        pe_state_e         state_q, state_d;
        logic [ADDR_W-1:0] cnt_q, cnt_d, n_q, n_d;
        logic              sum_q, sum_d, drain_q, drain_d;
        logic [LANE_W-1:0] sel_q, sel_d;
        logic              rvalid_q, rvalid_d;
        logic              start, rd_en, rd_last, idle, granted;
        logic [NUM_LANES-1:0][DATA_W-1:0] lane_rdata;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            n_d     = n_q;
            sum_d   = sum_q;
            drain_d = drain_q;
            start   = 1'b0;
            rd_en   = 1'b0;
            rd_last = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (simd__cntl__valid[p] & sys__pe__allSynchronized[p]) begin
                        n_d     = simd__cntl__rs0[p*ADDR_W +: ADDR_W];
                        sum_d   = (simd__cntl__rs1[p*2 +: 2] == OP_SUM);
                        cnt_d   = '0;
                        drain_d = 1'b0;
                        if (simd__cntl__rs0[p*ADDR_W +: ADDR_W] == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_READ;
                            start   = 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    rd_en   = 1'b1;
                    rd_last = (cnt_q == n_q - ADDR_W'(1));
                    cnt_d   = cnt_q + ADDR_W'(1);
                    if (rd_last) state_d = ST_DRAIN;
                end
                // Copy holds DRAIN one extra cycle so complete lands at N+2; sum leaves at once.
                ST_DRAIN: begin
                    if (sum_q | drain_q) state_d = ST_DONE;
                    else                 drain_d = 1'b1;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            idle     = (state_q == ST_IDLE);
            granted  = ldst__memc__request[p] & idle;
            sel_d    = ldst__memc__lane[p*LANE_W +: LANE_W];
            rvalid_d = granted & ldst__memc__read_valid[p];
        end

        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                n_q      <= '0;
                sum_q    <= 1'b0;
                drain_q  <= 1'b0;
                sel_q    <= '0;
                rvalid_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                n_q      <= n_d;
                sum_q    <= sum_d;
                drain_q  <= drain_d;
                sel_q    <= sel_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign pe__sys__ready[p]              = idle;
        assign pe__sys__complete[p]           = (state_q == ST_DONE);
        assign memc__ldst__granted[p]         = granted;
        assign memc__ldst__read_data_valid[p] = rvalid_q;
        assign memc__ldst__read_data[p*DATA_W +: DATA_W] = rvalid_q ? lane_rdata[sel_q] : '0;

        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            localparam int IDX = p*NUM_LANES + l;
            logic hit;
            assign hit = granted & (ldst__memc__lane[p*LANE_W +: LANE_W] == LANE_W'(l));

            pe_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
                .clk          (clk),
                .rst_n        (reset_poweron),
                .start        (start),
                .rd_en        (rd_en),
                .rd_last      (rd_last),
                .op_sum       (sum_q),
                .src_base     (simd__cntl__lane_r128[IDX*ADDR_W +: ADDR_W]),
                .dst_base     (simd__cntl__lane_r129[IDX*ADDR_W +: ADDR_W]),
                .ld_wr        (hit & ldst__memc__write_valid[p]),
                .ld_waddr     (ldst__memc__write_address[p*ADDR_W +: ADDR_W]),
                .ld_wdata     (ldst__memc__write_data[p*DATA_W +: DATA_W]),
                .ld_rd        (hit & ldst__memc__read_valid[p]),
                .ld_raddr     (ldst__memc__read_address[p*ADDR_W +: ADDR_W]),
                .dma_wr_valid (dma__memc__write_valid[IDX]),
                .dma_wr_addr  (dma__memc__write_address[IDX*ADDR_W +: ADDR_W]),
                .dma_wr_data  (dma__memc__write_data[IDX*DATA_W +: DATA_W]),
                .dma_rd_valid (dma__memc__read_valid[IDX]),
                .dma_rd_addr  (dma__memc__read_address[IDX*ADDR_W +: ADDR_W]),
                .rdata        (lane_rdata[l])
            );
        end
    end
endmodule

// File: tb/tb_pe_array_system.sv
// Randomized bench for pe_array_system: a word-level model of every lane memory predicts
// each DMA write (cycle, lane, address, data) and the complete pulse of each streaming op.
module tb_pe_array_system;
    localparam int NP = 2, NL = 2, DW = 32, AW = 8, LW = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [NP-1:0]       sync, valid, ready, complete;
    logic [NP*AW-1:0]    rs0;
    logic [NP*2-1:0]     rs1;
    logic [NP*NL*AW-1:0] r128, r129, wa, ra;
    logic [NP*NL-1:0]    wv, rv;
    logic [NP*NL*DW-1:0] wd;
    logic [NP-1:0]       req, granted, lwv, lrv, rdv;
    logic [NP*LW-1:0]    ld_lane;
    logic [NP*AW-1:0]    lwa, lra;
    logic [NP*DW-1:0]    lwd, rdata;

    pe_array_system #(.NUM_PE(NP), .NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_poweron(rst_n),
        .sys__pe__allSynchronized(sync), .simd__cntl__valid(valid),
        .simd__cntl__rs0(rs0), .simd__cntl__rs1(rs1),
        .simd__cntl__lane_r128(r128), .simd__cntl__lane_r129(r129),
        .pe__sys__ready(ready), .pe__sys__complete(complete),
        .dma__memc__write_valid(wv), .dma__memc__write_address(wa), .dma__memc__write_data(wd),
        .dma__memc__read_valid(rv), .dma__memc__read_address(ra),
        .ldst__memc__request(req), .memc__ldst__granted(granted), .ldst__memc__lane(ld_lane),
        .ldst__memc__write_valid(lwv), .ldst__memc__write_address(lwa), .ldst__memc__write_data(lwd),
        .ldst__memc__read_valid(lrv), .ldst__memc__read_address(lra),
        .memc__ldst__read_data(rdata), .memc__ldst__read_data_valid(rdv)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int idx; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

    logic [DW-1:0] mdl [NP][NL][256];
    wr_t  wq[$];
    wr_t  mon_e;
    int   cpl_cyc[$];
    int   rd_cnt = 0;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   op_pe, op_n, op_op, op_start;
    logic [AW-1:0] op_src [NL], op_dst [NL];
    logic [AW-1:0] src_a [NL], dst_a [NL];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NP*NL; i++) begin
                if (wv[i]) begin
                    mon_e.cyc = cyc; mon_e.idx = i;
                    mon_e.addr = wa[i*AW +: AW]; mon_e.data = wd[i*DW +: DW];
                    wq.push_back(mon_e);
                end
                if (rv[i]) rd_cnt++;
            end
            for (int p = 0; p < NP; p++) if (complete[p]) cpl_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ldst_wr(input int p, input int l, input int a, input logic [DW-1:0] d, input logic exp_grant);
        req[p] = 1'b1; lwv[p] = 1'b1;
        ld_lane[p*LW +: LW] = LW'(l); lwa[p*AW +: AW] = AW'(a); lwd[p*DW +: DW] = d;
        #1;
        chk("wr_grant", granted[p], exp_grant);
        tick();
        req[p] = 1'b0; lwv[p] = 1'b0;
        if (exp_grant) mdl[p][l][a] = d;
    endtask

    task automatic ldst_rd(input int p, input int l, input int a, input logic [DW-1:0] expd);
        req[p] = 1'b1; lrv[p] = 1'b1;
        ld_lane[p*LW +: LW] = LW'(l); lra[p*AW +: AW] = AW'(a);
        #1;
        chk("rd_grant", granted[p], 1'b1);
        tick();
        req[p] = 1'b0; lrv[p] = 1'b0;
        chk("rd_valid", rdv[p], 1'b1);
        chk("rd_data", rdata[p*DW +: DW], expd);
    endtask

    task automatic start_op(input int p, input int n, input int op, input logic [AW-1:0] src [NL],
                            input logic [AW-1:0] dst [NL], input int hold);
        wq.delete(); cpl_cyc.delete(); rd_cnt = 0;
        op_pe = p; op_n = n; op_op = op;
        for (int l = 0; l < NL; l++) begin
            op_src[l] = src[l]; op_dst[l] = dst[l];
            r128[(p*NL+l)*AW +: AW] = src[l];
            r129[(p*NL+l)*AW +: AW] = dst[l];
        end
        rs0[p*AW +: AW] = AW'(n); rs1[p*2 +: 2] = 2'(op);
        valid[p] = 1'b1; sync[p] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("hold_ready", ready[p], 1'b1);
            tick();
        end
        if (hold > 0) chk("hold_noread", rd_cnt, 0);
        sync[p] = 1'b1;
        op_start = cyc + 1;
        tick();
        // Scramble the descriptor: the op must run on the values captured at start.
        valid[p] = 1'b0;
        rs0[p*AW +: AW] = AW'($urandom); rs1[p*2 +: 2] = 2'($urandom);
        for (int l = 0; l < NL; l++) begin
            r128[(p*NL+l)*AW +: AW] = AW'($urandom);
            r129[(p*NL+l)*AW +: AW] = AW'($urandom);
        end
    endtask

    task automatic finish_op();
        wr_t xq[$];
        wr_t e;
        int t = 0;
        logic [DW-1:0] acc;
        while (cpl_cyc.size() == 0 && t < 1000) begin tick(); t++; end
        chk("cpl_seen", cpl_cyc.size() != 0, 1'b1);
        repeat (3) tick();
        chk("cpl_count", cpl_cyc.size(), 1);
        if (cpl_cyc.size() != 0)
            chk("cpl_lat", cpl_cyc[0] - op_start, (op_n == 0) ? 0 : ((op_op == 1) ? op_n + 1 : op_n + 2));
        chk("ready_after", ready[op_pe], 1'b1);
        chk("rd_count", rd_cnt, op_n * NL);
        if (op_n != 0) begin
            if (op_op == 1) begin
                for (int l = 0; l < NL; l++) begin
                    acc = '0;
                    for (int k = 0; k < op_n; k++) acc = acc + mdl[op_pe][l][(int'(op_src[l]) + k) % 256];
                    e.cyc = op_start + op_n; e.idx = op_pe*NL + l; e.addr = op_dst[l]; e.data = acc;
                    xq.push_back(e);
                end
            end else begin
                for (int k = 0; k < op_n; k++)
                    for (int l = 0; l < NL; l++) begin
                        e.cyc = op_start + k + 1; e.idx = op_pe*NL + l;
                        e.addr = AW'((int'(op_dst[l]) + k) % 256);
                        e.data = mdl[op_pe][l][(int'(op_src[l]) + k) % 256];
                        xq.push_back(e);
                    end
            end
        end
        chk("wr_count", wq.size(), xq.size());
        for (int i = 0; i < xq.size() && i < wq.size(); i++) begin
            chk("wr_cyc", wq[i].cyc, xq[i].cyc);
            chk("wr_lane", wq[i].idx, xq[i].idx);
            chk("wr_addr", wq[i].addr, xq[i].addr);
            chk("wr_data", wq[i].data, xq[i].data);
        end
        foreach (xq[i]) mdl[xq[i].idx / NL][xq[i].idx % NL][xq[i].addr] = xq[i].data;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, n, op, l, a, s;
        rst_n = 1'b0;
        sync = '0; valid = '0; rs0 = '0; rs1 = '0; r128 = '0; r129 = '0;
        req = '0; ld_lane = '0; lwv = '0; lwa = '0; lwd = '0; lrv = '0; lra = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 2'b11);
        chk("rst_cpl", complete, '0);
        chk("rst_wv", wv, '0);
        chk("rst_rv", rv, '0);
        chk("rst_rdv", rdv, '0);
        chk("rst_rdata", rdata, '0);
        rst_n = 1'b1;
        tick();

        // Load every lane memory of both PEs with random words.
        for (int li = 0; li < NL; li++)
            for (int ai = 0; ai < 256; ai++) begin
                for (int pi = 0; pi < NP; pi++) begin
                    req[pi] = 1'b1; lwv[pi] = 1'b1;
                    ld_lane[pi*LW +: LW] = LW'(li); lwa[pi*AW +: AW] = AW'(ai);
                    lwd[pi*DW +: DW] = $urandom;
                    mdl[pi][li][ai] = lwd[pi*DW +: DW];
                end
                tick();
            end
        req = '0; lwv = '0;

        for (int i = 0; i < 4; i++) ldst_wr(0, 0, i, DW'(i + 1), 1'b1);
        ldst_wr(0, 1, 254, 32'hA, 1'b1);
        ldst_wr(0, 1, 255, 32'hB, 1'b1);

        src_a[0] = 8'd0;  src_a[1] = 8'd0;   dst_a[0] = 8'd16;  dst_a[1] = 8'd16;
        start_op(0, 4, 1, src_a, dst_a, 0);
        finish_op();

        src_a[0] = 8'd100; src_a[1] = 8'd254; dst_a[0] = 8'd200; dst_a[1] = 8'd10;
        start_op(0, 3, 0, src_a, dst_a, 0);
        finish_op();
        ldst_rd(0, 1, 10, 32'hA);
        ldst_rd(0, 1, 11, 32'hB);

        start_op(1, 0, 0, src_a, dst_a, 0);
        finish_op();

        src_a[0] = 8'd5; src_a[1] = 8'd7; dst_a[0] = 8'd150; dst_a[1] = 8'd160;
        start_op(1, 2, 0, src_a, dst_a, 3);
        finish_op();

        src_a[0] = 8'd40; src_a[1] = 8'd40; dst_a[0] = 8'd100; dst_a[1] = 8'd100;
        start_op(0, 20, 0, src_a, dst_a, 0);
        ldst_wr(0, 0, 16, 32'hDEAD, 1'b0);
        finish_op();
        ldst_rd(0, 0, 16, 32'd10);

        for (int it = 0; it < 25; it++) begin
            p = $urandom_range(0, NP-1); n = $urandom_range(0, 12); op = $urandom_range(0, 3);
            for (int li = 0; li < NL; li++) begin
                s = $urandom_range(0, 255);
                src_a[li] = AW'(s);
                dst_a[li] = AW'((s + 64 + $urandom_range(0, 64)) % 256);
            end
            start_op(p, n, op, src_a, dst_a, $urandom_range(0, 2));
            finish_op();
            l = $urandom_range(0, NL-1); a = $urandom_range(0, 255);
            ldst_rd(p, l, a, mdl[p][l][a]);
        end

        src_a[0] = 8'd0; src_a[1] = 8'd0; dst_a[0] = 8'd90; dst_a[1] = 8'd90;
        start_op(1, 50, 1, src_a, dst_a, 0);
        repeat (5) tick();
        chk("mid_busy", ready[1], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 2'b11);
        chk("abort_cpl", complete, '0);
        chk("abort_wv", wv, '0);
        chk("abort_rv", rv, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        cpl_cyc.delete();
        repeat (60) tick();
        chk("abort_nocpl", cpl_cyc.size(), 0);
        chk("abort_nowr", wq.size(), 0);
        chk("abort_idle", ready, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_array_system.md
# pe_array_system

Compute-layer system top: an array of `NUM_PE` processing elements, each with `NUM_LANES` execution lanes, a private word memory per lane, and a streaming-operation controller. A scalar/lane register descriptor from the SIMD side starts a streaming op in which every lane DMA-reads a vector from its memory, processes it, and DMA-writes the result. DMA write/read strobes are exported per lane as probe outputs for result checking, and a load/store port gives the SIMD direct memory access while a PE is idle.

## Interface
- `NUM_PE`, 2: processing elements.
- `NUM_LANES`, 2: lanes per PE.
- `DATA_W`, 32: memory word width.
- `ADDR_W`, 8: lane memory address width; depth is 2^ADDR_W.

Ports. Per-PE signals are packed `[NUM_PE*w-1:0]`; per-PE/lane signals are packed `[NUM_PE*NUM_LANES*w-1:0]` with index `pe*NUM_LANES+lane`.
- `clk` in 1: single clock.
- `reset_poweron` in 1: asynchronous, active-low reset.
- `sys__pe__allSynchronized` in NUM_PE: start gate.
- `simd__cntl__valid` in NUM_PE: start request.
- `simd__cntl__rs0` in NUM_PE*ADDR_W: element count N.
- `simd__cntl__rs1` in NUM_PE*2: op (0 copy, 1 sum, 2–3 reserved, behave as copy).
- `simd__cntl__lane_r128` in NUM_PE*NUM_LANES*ADDR_W: source base address.
- `simd__cntl__lane_r129` in NUM_PE*NUM_LANES*ADDR_W: destination base address.
- `pe__sys__ready` out NUM_PE: PE idle.
- `pe__sys__complete` out NUM_PE: one-cycle done pulse.
- `dma__memc__write_valid`/`_write_address`/`_write_data` out per lane (1/ADDR_W/DATA_W): DMA write probe.
- `dma__memc__read_valid`/`_read_address` out per lane (1/ADDR_W): DMA read probe.
- `ldst__memc__request` in NUM_PE: SIMD memory access request.
- `memc__ldst__granted` out NUM_PE: request granted, which equals request AND idle.
- `ldst__memc__lane` in NUM_PE*clog2(NUM_LANES): target lane.
- `ldst__memc__write_valid`, `ldst__memc__write_address`, `ldst__memc__write_data` in: SIMD write.
- `ldst__memc__read_valid`, `ldst__memc__read_address` in: SIMD read.
- `memc__ldst__read_data` out NUM_PE*DATA_W: SIMD read data.
- `memc__ldst__read_data_valid` out NUM_PE: SIMD read data valid.

## Operation
- PE FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ when `valid & allSynchronized` and N≠0. Capture N, op, and all lane r128/r129 values.
- N=0: IDLE → DONE directly. No memory access.
- READ: cycle k (k=0..N-1) issues a read at `r128+k` in every lane in lockstep. After the last read, go to DRAIN.
- Copy: each returned word k is written to `r129+k`.
- Sum: a DATA_W accumulator, cleared on start, adds each word with wrap on overflow. The single write to `r129` is issued when the last word returns.
- DRAIN → DONE after the final write. DONE pulses `complete` for one cycle, then returns to IDLE.
- Addresses wrap modulo 2^ADDR_W. Overlapping src/dst reads the pre-op contents for addresses not yet written.
- `ready` is 1 only in IDLE. `valid` outside IDLE is ignored.
- ldst accesses are honoured only when granted; ungranted writes are dropped. A DMA access and a granted ldst access never coincide.

## Timing
- Memory: synchronous write, 1-cycle synchronous read.
- Copy: write k occurs at cycle k+1 after READ entry. `complete` asserts at cycle N+2.
- Sum: the single write occurs at cycle N. `complete` asserts at cycle N+1.
- ldst read data valid 1 cycle after `read_valid`.
- Reset values: all outputs 0 except `ready`=1. Accumulators 0, FSM IDLE. Memory contents undefined.
- Reset mid-op: abort immediately. No complete pulse; ready=1 after release.

## Structure
- Package `pe_array_system_pkg`: op encodings, FSM state enum, width constants.
- Sub-module `pe_lane`: lane memory, DMA address counters, accumulator, and ldst mux. The top instantiates `NUM_PE*NUM_LANES` lanes plus one FSM per PE.

## Test plan
- Sum: ldst-write 1,2,3,4 at addresses 0..3 of lane 0; start N=4, op=1, r128=0, r129=16 → one write of 10 at address 16; `complete` at cycle 5.
- Copy: lane 1 holds 0xA,0xB at 254,255; N=3, r128=254, r129=10 → writes 0xA,0xB,mem[0] to 10,11,12 (wrap).
- N=0 → complete pulse, no `write_valid`, ready returns 1.
- allSynchronized=0 with valid held → no start; raise it → start next cycle.
- ldst request while busy → granted=0, memory unchanged. When idle, a read of address 16 returns 10 one cycle later.
- Assert reset mid-READ → outputs zero, ready=1, no complete.
